// File: rtl/pong_match_ctrl.sv
// pong_match_ctrl
// Match sequencer for the Pong datapath. It owns the game state, both score
// registers, the serve delay and the winner decision. It freezes and recentres
// the ball/paddle machine and runs or reloads the match countdown timer.
//
// Ports
//   clk         system clock
//   rst         synchronous reset, active-high
//   tick        one-clk strobe at 100 Hz, time base of the serve delay
//   start       start button level (already synchronised)
//   miss1/miss2 player 1 / player 2 missed the ball (only looked at in PLAY)
//   time_up     match timer has reached 0:00 (level)
//   stop        freeze ball and paddles
//   ball_reset  one-clk pulse: recentre ball and load serve_dir
//   serve_dir   0 = serve toward player 1, 1 = serve toward player 2
//   timer_run   enable the match countdown
//   timer_load  one-clk pulse: reload the match timer to full time
//   score1/2    player scores
//   winner      00 none, 01 P1, 10 P2, 11 draw
//   state       current state code for the LEDs
// All outputs come straight from registers.

module pong_match_ctrl #(
   parameter int WIN_SCORE   = 7,
   parameter int SERVE_TICKS = 200,
   parameter int SCORE_W     = 3,
   parameter int CNT_W       = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               tick,
   input  logic               start,
   input  logic               miss1,
   input  logic               miss2,
   input  logic               time_up,
   output logic               stop,
   output logic               ball_reset,
   output logic               serve_dir,
   output logic               timer_run,
   output logic               timer_load,
   output logic [SCORE_W-1:0] score1,
   output logic [SCORE_W-1:0] score2,
   output logic [1:0]         winner,
   output logic [2:0]         state
);

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      SERVE_WAIT = 3'd1,
      PLAY       = 3'd2,
      POINT      = 3'd3,
      OVER       = 3'd4
   } state_t;

   localparam logic [SCORE_W-1:0] WIN_VAL   = SCORE_W'(WIN_SCORE);
   localparam logic [CNT_W-1:0]   SERVE_VAL = CNT_W'(SERVE_TICKS);

   state_t             state_q, state_n;
   logic [CNT_W-1:0]   cnt_q, cnt_n;
   logic               start_q;
   logic               start_rise;
   logic [SCORE_W-1:0] score1_n, score2_n;
   logic [1:0]         winner_n;
   logic               serve_dir_n;
   logic               ball_reset_n;
   logic               timer_load_n;
   logic               stop_n;
   logic               timer_run_n;

   // A held button must produce a single start event.
   assign start_rise = start & ~start_q;

   assign state = state_q;

   // State register and every output register. Reset forces the idle/frozen
   // picture and suppresses any pulse that would otherwise be emitted.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         start_q    <= 1'b0;
         score1     <= '0;
         score2     <= '0;
         winner     <= 2'b00;
         serve_dir  <= 1'b0;
         ball_reset <= 1'b0;
         timer_load <= 1'b0;
         stop       <= 1'b1;
         timer_run  <= 1'b0;
      end else begin
         state_q    <= state_n;
         cnt_q      <= cnt_n;
         start_q    <= start;
         score1     <= score1_n;
         score2     <= score2_n;
         winner     <= winner_n;
         serve_dir  <= serve_dir_n;
         ball_reset <= ball_reset_n;
         timer_load <= timer_load_n;
         stop       <= stop_n;
         timer_run  <= timer_run_n;
      end
   end

   // Next-state and next-output logic. Pulses default low so they can never
   // last more than one clock. stop/timer_run follow the state being entered
   // so they line up with the registered state code.
   always_comb begin
      state_n      = state_q;
      cnt_n        = cnt_q;
      score1_n     = score1;
      score2_n     = score2;
      winner_n     = winner;
      serve_dir_n  = serve_dir;
      ball_reset_n = 1'b0;
      timer_load_n = 1'b0;

      case (state_q)
         IDLE: begin
            if (start_rise) begin
               score1_n     = '0;
               score2_n     = '0;
               winner_n     = 2'b00;
               serve_dir_n  = 1'b0;
               cnt_n        = SERVE_VAL;
               timer_load_n = 1'b1;
               ball_reset_n = 1'b1;
               state_n      = SERVE_WAIT;
            end
         end

         SERVE_WAIT: begin
            // The zero check uses the register, so PLAY starts one clock
            // after the final tick has been counted.
            if (time_up) begin
               state_n = OVER;
            end else if (cnt_q == '0) begin
               state_n = PLAY;
            end else if (tick) begin
               cnt_n = cnt_q - CNT_W'(1);
            end
         end

         PLAY: begin
            if (time_up) begin
               state_n = OVER;
            end else if (miss1 && miss2) begin
               cnt_n        = SERVE_VAL;
               ball_reset_n = 1'b1;
               state_n      = SERVE_WAIT;
            end else if (miss1) begin
               if (score2 < WIN_VAL) begin
                  score2_n = score2 + SCORE_W'(1);
               end
               serve_dir_n = 1'b0;
               state_n     = POINT;
            end else if (miss2) begin
               if (score1 < WIN_VAL) begin
                  score1_n = score1 + SCORE_W'(1);
               end
               serve_dir_n = 1'b1;
               state_n     = POINT;
            end
         end

         POINT: begin
            if ((score1 == WIN_VAL) || (score2 == WIN_VAL)) begin
               state_n = OVER;
            end else begin
               cnt_n        = SERVE_VAL;
               ball_reset_n = 1'b1;
               state_n      = SERVE_WAIT;
            end
         end

         OVER: begin
            // Scores and winner stay visible until the next match starts.
            if (start_rise) begin
               state_n = IDLE;
            end
         end

         default: begin
            state_n = IDLE;
         end
      endcase

      // The winner is decided from the scores held at the moment OVER is
      // entered; by then any final point is already in the score registers.
      if ((state_n == OVER) && (state_q != OVER)) begin
         if (score1 > score2) begin
            winner_n = 2'b01;
         end else if (score2 > score1) begin
            winner_n = 2'b10;
         end else begin
            winner_n = 2'b11;
         end
      end

      stop_n      = (state_n != PLAY);
      timer_run_n = (state_n == PLAY);
   end

endmodule

// File: doc/pong_match_ctrl.md
Name: pong_match_ctrl

Overview:
Match sequencer for the Pong datapath. It owns the game state, both score registers, the serve delay and the winner decision. It drives the freeze/recentre controls of the ball/paddle state machine and the run/load controls of the countdown timer. It replaces the ad-hoc FSM in the top level and feeds scores to the dot-matrix drivers and state to the LEDs.

Parameters:
WIN_SCORE, 7, points that end the match immediately (must fit in SCORE_W bits).
SERVE_TICKS, 200, tick strobes spent in SERVE_WAIT (200 x 100 Hz = 2 s).
SCORE_W, 3, width of each score register.
CNT_W, 8, width of the serve-delay counter (must hold SERVE_TICKS).

Ports:
clk  in  1  system clock.
rst  in  1  synchronous reset, active-high.
tick  in  1  one-clk strobe at 100 Hz, the serve-delay time base.
start  in  1  start button, level, already synchronised.
miss1  in  1  player 1 missed the ball; sampled in PLAY only.
miss2  in  1  player 2 missed the ball; sampled in PLAY only.
time_up  in  1  match timer has reached 0:00, level.
stop  out  1  freeze ball and paddles.
ball_reset  out  1  one-clk pulse: recentre ball and load serve_dir.
serve_dir  out  1  0 = serve toward player 1, 1 = serve toward player 2.
timer_run  out  1  enable the match countdown.
timer_load  out  1  one-clk pulse: reload the match timer to full time.
score1  out  SCORE_W  player 1 score.
score2  out  SCORE_W  player 2 score.
winner  out  2  00 = none, 01 = P1, 10 = P2, 11 = draw.
state  out  3  current state code, for the LEDs.

Behaviour:
- All outputs are registered.
- On reset (at a clk edge with rst=1):
  - state=IDLE, score1=score2=0, winner=00.
  - stop=1, ball_reset=0, timer_load=0, timer_run=0, serve_dir=0.
  - Serve counter=0, start history register=0.
- Reset mid-match aborts immediately; no pulses are emitted in the reset cycle.
- start_rise = start & ~start_q, where start_q is the registered previous value of start. A held button produces one event only.
- State codes: IDLE=0, SERVE_WAIT=1, PLAY=2, POINT=3, OVER=4. Codes 5-7 return to IDLE on the next clk.
- IDLE:
  - stop=1, timer_run=0.
  - On start_rise: score1=score2=0, winner=00, serve_dir=0, counter=SERVE_TICKS.
  - Same edge: timer_load and ball_reset are each 1 for the following clk; next state SERVE_WAIT.
- SERVE_WAIT:
  - stop=1, timer_run=0.
  - Counter decrements by 1 on each tick.
  - When the counter register reads 0, the next state is PLAY. PLAY is entered exactly SERVE_TICKS ticks after entry, plus 1 clk.
  - time_up=1 has priority and goes to OVER.
  - start is ignored.
- PLAY:
  - stop=0, timer_run=1.
  - Priority is time_up > (miss1 & miss2) > miss1 > miss2.
  - time_up: go to OVER; scores unchanged.
  - Both misses in the same clk: no point awarded, serve_dir unchanged, counter=SERVE_TICKS, ball_reset pulse, go to SERVE_WAIT.
  - miss1 only: score2 += 1, serve_dir=0, go to POINT.
  - miss2 only: score1 += 1, serve_dir=1, go to POINT.
  - Score increments saturate at WIN_SCORE; the register never wraps.
- POINT (exactly 1 clk, stop=1, timer_run=0):
  - If score1==WIN_SCORE or score2==WIN_SCORE: go to OVER.
  - Otherwise: counter=SERVE_TICKS, ball_reset pulse, go to SERVE_WAIT.
  - miss inputs are ignored here.
- OVER:
  - stop=1, timer_run=0.
  - winner is set on entry: 01 if score1>score2, 10 if score2>score1, 11 if equal. It is held until the next start from IDLE.
  - On start_rise: go to IDLE; scores stay visible until the IDLE start_rise clears them.
- Latency:
  - Miss to score update: 1 clk.
  - Miss to ball_reset: 2 clk (via POINT).
  - time_up to stop=1: 1 clk.
- timer_load and ball_reset never stay high longer than 1 clk.

Test Plan:
1. Reset and first serve (params WIN_SCORE=3, SERVE_TICKS=4, tick every 5 clk): assert rst 2 clk, then pulse start high 1 clk.
   -> state=0, stop=1 during reset; after start: timer_load=1 and ball_reset=1 for 1 clk, state=1; state=2 and stop=0 exactly 4 ticks + 1 clk later.
2. Single point: in PLAY pulse miss2 for 1 clk.
   -> next clk score1=1, serve_dir=1, state=3; next clk ball_reset=1, state=1; PLAY resumes after 4 ticks.
3. Simultaneous miss: miss1=miss2=1 in the same clk during PLAY.
   -> scores unchanged, serve_dir unchanged, ball_reset pulse, state=1.
4. Win: drive three miss1 events.
   -> score2=3, POINT goes to OVER, winner=10, stop=1, timer_run=0; further misses are ignored.
5. Time out with draw: with score1=score2=1 in PLAY, raise time_up.
   -> state=4 next clk, winner=11; time_up raised during SERVE_WAIT also reaches OVER.
6. Held start and mid-match reset: hold start high for 50 clk from IDLE, then assert rst while in PLAY.
   -> only one start event, no re-trigger on OVER; rst returns all outputs to reset values in 1 clk.
